// File: rtl/vga_rx_monitor.sv
// Receive-side VGA timing monitor: recovers the pixel grid from sync/valid/RGB on pclk,
// writes locked pixels as (x, y, rgb) strobes and reports per-frame timing, errors and checksum.
module vga_rx_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int V_TOTAL     = 525,
  parameter int H_ACT       = 640,
  parameter int V_ACT       = 480,
  parameter int LOCK_FRAMES = 2
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        pix_we,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        locked,
  output logic        frame_done,
  output logic [9:0]  meas_hlen,
  output logic [9:0]  meas_vlen,
  output logic [31:0] frame_sum,
  output logic [3:0]  err
);

  typedef enum logic [1:0] {HUNT = 2'd0, MEASURE = 2'd1, LOCKED = 2'd2} state_t;

  localparam logic [9:0] H_TOTAL_C = 10'(H_TOTAL);
  localparam logic [9:0] V_TOTAL_C = 10'(V_TOTAL);
  localparam logic [9:0] H_ACT_C   = 10'(H_ACT);
  localparam logic [9:0] V_ACT_C   = 10'(V_ACT);
  localparam logic [3:0] LOCK_C    = 4'(LOCK_FRAMES);

  function automatic logic [9:0] sat_inc(input logic [9:0] v, input logic en);
    logic [9:0] r;
    if (en && (v != 10'd1023)) r = v + 10'd1;
    else                       r = v;
    return r;
  endfunction

  logic        s_hs_r, s_vs_r, s_valid_r, p_hs_r, p_vs_r;
  logic [23:0] s_rgb_r;
  logic [9:0]  h_cnt_r, v_cnt_r, act_x_r, act_y_r;
  logic        line_active_r;
  logic [31:0] sum_r;
  logic [3:0]  acc_err_r;
  state_t      state_r, state_nx_s;
  logic [3:0]  good_cnt_r, good_nx_s, good_inc_s;
  logic        done_s, pix_we_s, sync_lost_s;
  logic        hfall_s, vfall_s;
  logic [9:0]  act_y_fin_s;
  logic [3:0]  frame_err_s;

  assign hfall_s     = p_hs_r & ~s_hs_r;
  assign vfall_s     = p_vs_r & ~s_vs_r;
  // A line ending on this cycle still counts toward the frame that vfall closes.
  assign act_y_fin_s = sat_inc(act_y_r, hfall_s & line_active_r);
  assign frame_err_s = acc_err_r | {vfall_s & (act_y_fin_s != V_ACT_C),
                                    hfall_s & line_active_r & (act_x_r != H_ACT_C),
                                    vfall_s & (v_cnt_r != V_TOTAL_C),
                                    hfall_s & (h_cnt_r != H_TOTAL_C)};
  // Next edge would take h_cnt to (or keep it at) saturation: sync is considered lost.
  assign sync_lost_s = ~hfall_s & (h_cnt_r >= 10'd1022);
  assign good_inc_s  = good_cnt_r + 4'd1;
  assign pix_we_s    = s_valid_r & (state_r == LOCKED) & (state_nx_s == LOCKED);

  // Input sample stage and previous-sync history for edge detection.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      s_hs_r    <= 1'b0;
      s_vs_r    <= 1'b0;
      s_valid_r <= 1'b0;
      s_rgb_r   <= 24'd0;
      p_hs_r    <= 1'b0;
      p_vs_r    <= 1'b0;
    end else begin
      s_hs_r    <= hsync;
      s_vs_r    <= vsync;
      s_valid_r <= valid;
      s_rgb_r   <= {vga_r, vga_g, vga_b};
      p_hs_r    <= s_hs_r;
      p_vs_r    <= s_vs_r;
    end
  end

  // Line/frame counters, active-pixel position, checksum and error accumulators.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      h_cnt_r       <= 10'd0;
      v_cnt_r       <= 10'd0;
      act_x_r       <= 10'd0;
      act_y_r       <= 10'd0;
      line_active_r <= 1'b0;
      sum_r         <= 32'd0;
      acc_err_r     <= 4'd0;
    end else begin
      h_cnt_r       <= hfall_s ? 10'd1 : sat_inc(h_cnt_r, 1'b1);
      v_cnt_r       <= vfall_s ? 10'd1 : sat_inc(v_cnt_r, hfall_s);
      act_x_r       <= hfall_s ? {9'd0, s_valid_r} : sat_inc(act_x_r, s_valid_r);
      line_active_r <= hfall_s ? s_valid_r : (line_active_r | s_valid_r);
      act_y_r       <= vfall_s ? 10'd0 : act_y_fin_s;
      if (vfall_s) sum_r <= s_valid_r ? {8'd0, s_rgb_r} : 32'd0;
      else if (s_valid_r) sum_r <= sum_r + {8'd0, s_rgb_r};
      acc_err_r     <= vfall_s ? 4'd0 : frame_err_s;
    end
  end

  // Lock FSM state register.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_r    <= HUNT;
      good_cnt_r <= 4'd0;
    end else begin
      state_r    <= state_nx_s;
      good_cnt_r <= good_nx_s;
    end
  end

  // Lock FSM next-state and frame_done decision.
  always_comb begin
    state_nx_s = state_r;
    good_nx_s  = good_cnt_r;
    done_s     = 1'b0;
    if (sync_lost_s) begin
      state_nx_s = HUNT;
      good_nx_s  = 4'd0;
    end else if (vfall_s) begin
      case (state_r)
        HUNT: begin
          state_nx_s = MEASURE;
          good_nx_s  = 4'd0;
        end
        MEASURE: begin
          done_s = 1'b1;
          if (frame_err_s == 4'd0) begin
            good_nx_s  = good_inc_s;
            state_nx_s = (good_inc_s >= LOCK_C) ? LOCKED : MEASURE;
          end else begin
            good_nx_s  = 4'd0;
            state_nx_s = MEASURE;
          end
        end
        LOCKED: begin
          done_s = 1'b1;
          if (frame_err_s != 4'd0) begin
            good_nx_s  = 4'd0;
            state_nx_s = MEASURE;
          end else begin
            state_nx_s = LOCKED;
          end
        end
        default: begin
          state_nx_s = HUNT;
          good_nx_s  = 4'd0;
        end
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Registered pixel strobes and per-frame status.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      pix_we     <= 1'b0;
      pix_x      <= 10'd0;
      pix_y      <= 10'd0;
      pix_rgb    <= 24'd0;
      locked     <= 1'b0;
      frame_done <= 1'b0;
      meas_hlen  <= 10'd0;
      meas_vlen  <= 10'd0;
      frame_sum  <= 32'd0;
      err        <= 4'd0;
    end else begin
      pix_we     <= pix_we_s;
      locked     <= (state_nx_s == LOCKED);
      frame_done <= done_s;
      if (pix_we_s) begin
        pix_x   <= hfall_s ? 10'd0 : act_x_r;
        pix_y   <= vfall_s ? 10'd0 : act_y_fin_s;
        pix_rgb <= s_rgb_r;
      end
      if (done_s) begin
        meas_hlen <= h_cnt_r;
        meas_vlen <= v_cnt_r;
        frame_sum <= sum_r;
        err       <= frame_err_s;
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed + randomized bench for vga_rx_monitor on a reduced raster, checked against
// a frame-level reference model (expected reports and pixel writes in queues).
module tb_vga_rx_monitor;
  localparam int H_TOTAL = 40, V_TOTAL = 20, H_ACT = 16, V_ACT = 12, LOCK = 2;
  localparam int HS_W = 4, HBP = 8, VS_W = 2, VBP = 4, SPECIAL = 6;
  localparam int K_NORM = 0, K_SHORT = 1, K_MISS = 2, K_SYNC = 3, K_RST = 4;

  logic        pclk = 1'b0, reset = 1'b0, hsync = 1'b1, vsync = 1'b1, valid = 1'b0;
  logic [7:0]  vga_r = 8'd0, vga_g = 8'd0, vga_b = 8'd0;
  logic        pix_we, locked, frame_done;
  logic [9:0]  pix_x, pix_y, meas_hlen, meas_vlen;
  logic [23:0] pix_rgb;
  logic [31:0] frame_sum;
  logic [3:0]  err;

  vga_rx_monitor #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL), .H_ACT(H_ACT), .V_ACT(V_ACT),
                   .LOCK_FRAMES(LOCK)) dut (
    .pclk(pclk), .reset(reset), .hsync(hsync), .vsync(vsync), .valid(valid),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b), .pix_we(pix_we), .pix_x(pix_x),
    .pix_y(pix_y), .pix_rgb(pix_rgb), .locked(locked), .frame_done(frame_done),
    .meas_hlen(meas_hlen), .meas_vlen(meas_vlen), .frame_sum(frame_sum), .err(err));

  always #5 pclk = ~pclk;

  typedef struct { logic [9:0] hlen; logic [9:0] vlen; logic [3:0] err; logic [31:0] sum; logic lck; } rep_t;
  typedef struct { logic [9:0] x; logic [9:0] y; logic [23:0] rgb; } pix_t;

  rep_t exp_q[$];
  pix_t pix_q[$];
  int   tests = 0, fails = 0;
  bit   m_hunt = 1'b1, m_locked = 1'b0, m_hlen_bad, m_hact_bad;
  int   m_good = 0, m_lines, m_act_lines, m_last_len, pix_cnt = 0;
  logic [31:0] m_sum;
  logic [9:0]  last_x, last_y;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    rep_t r;
    pix_t p;
    if (frame_done) begin
      tests++;
      assert (exp_q.size() != 0) else begin
        fails++;
        $error("FAIL frame_done_unexpected: observed pulse expected none");
      end
      if (exp_q.size() != 0) begin
        r = exp_q.pop_front();
        chk("meas_hlen", meas_hlen, r.hlen);
        chk("meas_vlen", meas_vlen, r.vlen);
        chk("err", err, r.err);
        chk("frame_sum", frame_sum, r.sum);
        chk("locked_at_done", locked, r.lck);
      end
    end
    if (pix_we) begin
      pix_cnt++;
      last_x = pix_x;
      last_y = pix_y;
      tests++;
      assert (pix_q.size() != 0) else begin
        fails++;
        $error("FAIL pix_we_unexpected: observed x=%0d y=%0d expected no write", pix_x, pix_y);
      end
      if (pix_q.size() != 0) begin
        p = pix_q.pop_front();
        chk("pix_x", pix_x, p.x);
        chk("pix_y", pix_y, p.y);
        chk("pix_rgb", pix_rgb, p.rgb);
      end
    end
  endtask

  task automatic cyc(input logic hs, input logic vs, input logic v, input logic [23:0] rgb);
    hsync = hs;
    vsync = vs;
    valid = v;
    {vga_r, vga_g, vga_b} = rgb;
    @(posedge pclk);
    @(negedge pclk);
    check_outputs();
  endtask

  task automatic chk_all_zero();
    chk("rst_pix", {pix_we, pix_x, pix_y, pix_rgb}, 64'd0);
    chk("rst_status", {locked, frame_done, meas_hlen, meas_vlen, err}, 64'd0);
    chk("rst_sum", frame_sum, 64'd0);
  endtask

  // Frame boundary (vsync falling): close the model frame and predict its report.
  task automatic boundary();
    rep_t r;
    logic [3:0] e;
    if (m_hunt) begin
      m_hunt = 1'b0;
      m_good = 0;
    end else begin
      e = {m_act_lines != V_ACT, m_hact_bad, m_lines != V_TOTAL, m_hlen_bad};
      if (e == 4'd0) begin
        m_good++;
        if (m_good >= LOCK) m_locked = 1'b1;
      end else begin
        m_good = 0;
        m_locked = 1'b0;
      end
      r.hlen = 10'(m_last_len); r.vlen = 10'(m_lines); r.err = e; r.sum = m_sum; r.lck = m_locked;
      exp_q.push_back(r);
    end
    m_lines = 0; m_act_lines = 0; m_last_len = 0; m_sum = 32'd0;
    m_hlen_bad = 1'b0; m_hact_bad = 1'b0;
  endtask

  task automatic sync_loss();
    bit was_locked;
    was_locked = m_locked;
    for (int i = 0; i < 1100; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 24'($urandom()));
      if (i == 800) chk("locked_before_saturation", locked, was_locked);
    end
    chk("locked_after_sync_loss", locked, 1'b0);
    m_hunt = 1'b1; m_locked = 1'b0; m_good = 0;
  endtask

  task automatic mid_reset();
    reset = 1'b1;
    #1;
    chk_all_zero();
    pix_q.delete();
    m_hunt = 1'b1; m_locked = 1'b0; m_good = 0;
    hsync = 1'b1; vsync = 1'b1; valid = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    reset = 1'b0;
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 24'd0);
  endtask

  task automatic drive_frame(input int kind, input bit rnd, input logic [23:0] rgb_c);
    for (int l = 0; l < V_TOTAL; l++) begin
      int len, nv;
      logic v;
      logic [23:0] px;
      pix_t p;
      if (l == 0) boundary();
      len = (kind == K_SHORT && l == SPECIAL) ? H_TOTAL - 1 : H_TOTAL;
      nv = 0;
      for (int c = 0; c < len; c++) begin
        if (kind == K_SYNC && l == SPECIAL && c == HS_W) begin sync_loss(); return; end
        if (kind == K_RST && l == SPECIAL && c == HBP + 4) begin mid_reset(); return; end
        v = (l >= VBP) && (l < VBP + V_ACT) && (c >= HBP) && (c < HBP + H_ACT) &&
            !(kind == K_MISS && l == SPECIAL && c == HBP + H_ACT - 1);
        px = (v && !rnd) ? rgb_c : 24'($urandom());
        if (v) begin
          if (m_locked) begin
            p.x = 10'(nv); p.y = 10'(m_act_lines); p.rgb = px;
            pix_q.push_back(p);
          end
          m_sum = m_sum + {8'h00, px};
          nv++;
        end
        cyc(c >= HS_W, l >= VS_W, v, px);
      end
      m_lines++;
      m_last_len = len;
      if (len != H_TOTAL) m_hlen_bad = 1'b1;
      if (nv > 0) begin
        m_act_lines++;
        if (nv != H_ACT) m_hact_bad = 1'b1;
      end
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    #2 chk_all_zero();
    @(negedge pclk);
    @(negedge pclk);
    reset = 1'b0;
    repeat (8) cyc(1'b1, 1'b1, 1'b0, 24'd0);
    // Nominal lock with solid colour 0x000001.
    drive_frame(K_NORM, 1'b0, 24'h000001);
    drive_frame(K_NORM, 1'b0, 24'h000001);
    drive_frame(K_NORM, 1'b0, 24'h000001);
    chk("locked_after_two_frames", locked, 1'b1);
    pix_cnt = 0;
    drive_frame(K_NORM, 1'b0, 24'h000001);
    chk("first_locked_frame_pix_count", pix_cnt, H_ACT * V_ACT);
    // Full white frame, grid corners.
    pix_cnt = 0;
    drive_frame(K_NORM, 1'b0, 24'hFFFFFF);
    chk("white_pix_count", pix_cnt, H_ACT * V_ACT);
    chk("white_last_x", last_x, H_ACT - 1);
    chk("white_last_y", last_y, V_ACT - 1);
    drive_frame(K_NORM, 1'b1, 24'd0);
    drive_frame(K_NORM, 1'b1, 24'd0);
    // Short line while locked, then relock.
    drive_frame(K_SHORT, 1'b1, 24'd0);
    repeat (3) drive_frame(K_NORM, 1'b1, 24'd0);
    // One active line missing its last valid pixel.
    drive_frame(K_MISS, 1'b1, 24'd0);
    repeat (3) drive_frame(K_NORM, 1'b1, 24'd0);
    // Sync loss mid-frame and re-acquisition through HUNT.
    drive_frame(K_SYNC, 1'b1, 24'd0);
    repeat (3) drive_frame(K_NORM, 1'b1, 24'd0);
    // Asynchronous reset mid-line while locked.
    drive_frame(K_RST, 1'b1, 24'd0);
    repeat (3) drive_frame(K_NORM, 1'b1, 24'd0);
    boundary();
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 24'd0);
    repeat (6) cyc(1'b1, 1'b1, 1'b0, 24'd0);
    chk("reports_drained", exp_q.size(), 0);
    chk("pixels_drained", pix_q.size(), 0);
    chk("final_locked", locked, m_locked);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
